// File: rtl/phys_bus_ctl.sv
// -----------------------------------------------------------------------------
// phys_bus_ctl
//   Runs one CPU data access on the physical memory bus. An access is accepted
//   in IDLE and its operands are latched. It is checked for an odd word address
//   and then for write protection. A clean access runs a single strobed bus
//   cycle that ends on mem_ack_i or on a timeout. The result is reported for
//   one ce cycle. The controller then waits for the CPU to drop req_i.
//
//   States
//     state     | meaning
//     ----------+-----------------------------------------------------------
//     S_IDLE    | no access in flight; accepts req_i and runs the checks
//     S_BUS     | mem_stb_o high; waits for mem_ack_i or the timeout
//     S_RESP    | done_o or fault_o high for one ce cycle
//     S_RELEASE | waits for req_i low so a held request is not re-issued
//
// Ports
//   clk, reset       clock; asynchronous active-high reset
//   ce               clock enable; all state holds while low
//   req_i .. wdata_i CPU request, direction, size, address, permission, data
//   rdata_o          read result; holds between read completions
//   done_o, fault_o  one-ce-cycle completion / abort flags
//   fault_cause_o    01 write-protect, 10 odd address, 11 timeout, 00 none
//   mem_*            physical bus: word address, lanes, data, strobe, ack
// -----------------------------------------------------------------------------
module phys_bus_ctl #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        req_i,
  input  logic        we_i,
  input  logic        byte_i,
  input  logic [21:0] phaddr_i,
  input  logic        writable_i,
  input  logic [15:0] wdata_i,
  output logic [15:0] rdata_o,
  output logic        done_o,
  output logic        fault_o,
  output logic [1:0]  fault_cause_o,
  output logic [20:0] mem_addr_o,
  output logic [15:0] mem_wdata_o,
  output logic [1:0]  mem_be_o,
  output logic        mem_we_o,
  output logic        mem_stb_o,
  input  logic        mem_ack_i,
  input  logic [15:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUS     = 2'd1,
    S_RESP    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  localparam logic [7:0] CNT_TC     = 8'(TIMEOUT - 1);
  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_WP   = 2'b01;
  localparam logic [1:0] CAUSE_ODD  = 2'b10;
  localparam logic [1:0] CAUSE_TMO  = 2'b11;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  cause_q, cause_d;
  logic        latch_en;
  logic        capture_en;

  logic [21:0] addr_q;
  logic        we_q;
  logic        byte_q;
  logic        writable_q;
  logic [15:0] wdata_q;
  logic [7:0]  rd_lane;
  logic [1:0]  lanes;

  // State, timeout counter and result cause.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      cause_q <= CAUSE_NONE;
    end else if (ce) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  // Request operands, captured once per accepted access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q     <= 22'd0;
      we_q       <= 1'b0;
      byte_q     <= 1'b0;
      writable_q <= 1'b0;
      wdata_q    <= 16'd0;
    end else if (ce && latch_en) begin
      addr_q     <= phaddr_i;
      we_q       <= we_i;
      byte_q     <= byte_i;
      writable_q <= writable_i;
      wdata_q    <= wdata_i;
    end
  end

  // Read data only updates on an acknowledged read.
  assign rd_lane = addr_q[0] ? mem_rdata_i[15:8] : mem_rdata_i[7:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_o <= 16'd0;
    end else if (ce && capture_en) begin
      rdata_o <= byte_q ? {8'h00, rd_lane} : mem_rdata_i;
    end
  end

  assign lanes = !byte_q   ? 2'b11 :
                 addr_q[0] ? 2'b10 : 2'b01;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cause_d       = cause_q;
    latch_en      = 1'b0;
    capture_en    = 1'b0;
    done_o        = 1'b0;
    fault_o       = 1'b0;
    fault_cause_o = CAUSE_NONE;
    mem_stb_o     = 1'b0;
    mem_we_o      = 1'b0;
    mem_be_o      = 2'b00;
    mem_addr_o    = addr_q[21:1];
    mem_wdata_o   = byte_q ? {wdata_q[7:0], wdata_q[7:0]} : wdata_q;

    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          latch_en = 1'b1;
          // The odd-address check outranks write protection.
          if (!byte_i && phaddr_i[0]) begin
            cause_d = CAUSE_ODD;
            state_d = S_RESP;
          end else if (we_i && !writable_i) begin
            cause_d = CAUSE_WP;
            state_d = S_RESP;
          end else begin
            cause_d = CAUSE_NONE;
            cnt_d   = 8'd0;
            state_d = S_BUS;
          end
        end
      end

      S_BUS: begin
        mem_stb_o = 1'b1;
        // writable_q is redundant here because a protected write never reaches
        // S_BUS. It still keeps a write strobe off the bus if that ever breaks.
        mem_we_o  = we_q && writable_q;
        mem_be_o  = lanes;
        // An ack on the terminal-count edge still completes successfully.
        if (mem_ack_i) begin
          capture_en = !we_q;
          cause_d    = CAUSE_NONE;
          state_d    = S_RESP;
        end else if (cnt_q == CNT_TC) begin
          cause_d = CAUSE_TMO;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_RESP: begin
        done_o        = (cause_q == CAUSE_NONE);
        fault_o       = (cause_q != CAUSE_NONE);
        fault_cause_o = cause_q;
        state_d       = S_RELEASE;
      end

      S_RELEASE: begin
        if (!req_i) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: doc/phys_bus_ctl.md
PHYS_BUS_CTL -- requirements
Module: phys_bus_ctl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, max ce-qualified cycles mem_stb_o waits for mem_ack_i (range 2..255).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port ce  input  1  clock enable; state and outputs hold when low.
REQ-005 SHALL have port req_i  input  1  CPU access request, level, held until done_o or fault_o.
REQ-006 SHALL have port we_i  input  1  1 = write, 0 = read.
REQ-007 SHALL have port byte_i  input  1  1 = byte access, 0 = word access.
REQ-008 SHALL have port phaddr_i  input  22  translated physical byte address from the MMU.
REQ-009 SHALL have port writable_i  input  1  MMU page write permission.
REQ-010 SHALL have port wdata_i  input  16  write data, byte data in [7:0].
REQ-011 SHALL have port rdata_o  output  16  read result.
REQ-012 SHALL have port done_o  output  1  access completed successfully.
REQ-013 SHALL have port fault_o  output  1  access aborted.
REQ-014 SHALL have port fault_cause_o  output  2  01 write-protect, 10 odd address, 11 bus timeout, 00 none.
REQ-015 SHALL have ports mem_addr_o output 21 (word address), mem_wdata_o output 16, mem_be_o output 2, mem_we_o output 1, mem_stb_o output 1, mem_ack_i input 1, mem_rdata_i input 16.

Function
REQ-016 SHALL implement FSM IDLE, BUS, RESP, RELEASE; transitions only on clk edges with ce=1.
REQ-017 IDLE with req_i=1: SHALL latch phaddr_i, we_i, byte_i, wdata_i, writable_i.
REQ-018 Odd-address check SHALL take priority: byte_i=0 and phaddr_i[0]=1 -> RESP with fault cause 10.
REQ-019 Write-protect check SHALL follow: we_i=1 and writable_i=0 -> RESP with fault cause 01.
REQ-020 Faulted accesses SHALL never assert mem_stb_o or mem_we_o.
REQ-021 Otherwise: SHALL go to BUS, clear timeout counter, assert mem_stb_o from the same edge.
REQ-022 Bus mapping SHALL be mem_addr_o = phaddr[21:1]; mem_we_o = latched we, qualified by mem_stb_o.
REQ-023 Byte lanes SHALL be mem_be_o = 11 for word, 01 for byte with phaddr[0]=0, 10 for byte with phaddr[0]=1.
REQ-024 Byte writes SHALL drive mem_wdata_o = {wdata[7:0], wdata[7:0]}; word writes SHALL drive wdata unchanged.
REQ-025 In BUS, ce edge with mem_ack_i=1: SHALL drop mem_stb_o and go to RESP with success.
REQ-026 Read capture on ack SHALL be rdata_o = mem_rdata_i for word, {8'h00, selected byte lane} for byte; rdata_o SHALL otherwise hold.
REQ-027 In BUS without ack, counter SHALL increment per ce edge; at counter = TIMEOUT-1, SHALL drop mem_stb_o and go to RESP with cause 11.
REQ-028 Ack and timeout on the same edge: ack SHALL win.
REQ-029 In RESP: exactly one of done_o/fault_o SHALL be high for exactly one ce cycle; fault_cause_o valid in that cycle and 00 otherwise.
REQ-030 Next edge SHALL go to RELEASE.
REQ-031 RELEASE SHALL wait for req_i=0 sampled on a ce edge, then return to IDLE; no re-issue of a held request.
REQ-032 req_i dropping mid-BUS SHALL NOT abort the cycle.
REQ-033 Minimum latency SHALL be: req accepted at edge k, ack at edge k+1, done_o high between k+1 and k+2.

Reset
REQ-034 On reset=1, immediately and independent of clk/ce: SHALL force state IDLE, counter 0, and all outputs to 0 (rdata_o 16'h0000, mem_be_o 00, mem_addr_o 0).
REQ-035 Reset mid-BUS SHALL drop mem_stb_o asynchronously, with no done_o or fault_o.

Verification
REQ-036 Bench SHALL cover word read: phaddr 22'h001000, ack after 3 cycles, mem_rdata 16'hA5C3 -> mem_addr 21'h000800, be 11, done_o one cycle, rdata_o 16'hA5C3.
REQ-037 Bench SHALL cover byte write: phaddr 22'h000201, wdata 16'h1234, writable=1 -> be 10, mem_wdata 16'h3434, we=1, done_o.
REQ-038 Bench SHALL cover write-protect: we=1, writable=0 -> no mem_stb_o, fault_o one cycle with cause 01; odd word read (phaddr 22'h000003) -> cause 10.
REQ-039 Bench SHALL cover timeout: TIMEOUT=4, no ack -> mem_stb_o high exactly 4 ce cycles, then fault_o with cause 11; ack on the 4th cycle -> done_o instead.
REQ-040 Bench SHALL cover ce gating and reset: ce toggling 1/0 stretches all timing 2x; reset asserted mid-BUS drops stb same cycle, all outputs 0.
